// File: rtl/mult_accum_stage_if.sv
// Signal bundle between multiplier-side issue logic, the accumulator stage and its consumer.
// out_sat exists only when MULT_ACC_SAT_EN is defined.
interface mult_accum_stage_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int COUNT_W   = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     p_in;
  logic [COUNT_W-1:0]   frame_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [COUNT_W-1:0]   out_count;
  logic                 overflow_err;
  logic                 busy;
`ifdef MULT_ACC_SAT_EN
  logic                 out_sat;

  modport master (
    output in_valid, p_in, frame_len, out_ready,
    input  out_valid, out_sum, out_count, overflow_err, busy, out_sat
  );

  modport slave (
    input  in_valid, p_in, frame_len, out_ready,
    output out_valid, out_sum, out_count, overflow_err, busy, out_sat
  );
`else
  modport master (
    output in_valid, p_in, frame_len, out_ready,
    input  out_valid, out_sum, out_count, overflow_err, busy
  );

  modport slave (
    input  in_valid, p_in, frame_len, out_ready,
    output out_valid, out_sum, out_count, overflow_err, busy
  );
`endif
endinterface

// File: rtl/mult_accum_stage.sv
// Frames products from a fixed-latency multiplier, sums each frame and queues sums in a 2-deep FWFT FIFO.
// Define MULT_ACC_SAT_EN for a saturating accumulator with a per-entry out_sat flag.
module mult_accum_stage #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int LATENCY   = 3,
  parameter int COUNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  mult_accum_stage_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

`ifdef MULT_ACC_SAT_EN
  localparam int SUM_W   = ACC_WIDTH + 1;
  localparam int ENTRY_W = ACC_WIDTH + COUNT_W + 1;
`else
  localparam int SUM_W   = ACC_WIDTH;
  localparam int ENTRY_W = ACC_WIDTH + COUNT_W;
`endif

  state_t               r_state;
  logic [LATENCY-1:0]   r_vpipe;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [COUNT_W-1:0]   r_cnt;
  logic [COUNT_W-1:0]   r_len;
  logic [ENTRY_W-1:0]   r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_fill;
  logic                 r_ovf;
`ifdef MULT_ACC_SAT_EN
  logic                 r_sat;
  logic                 w_sat_next;
`endif

  logic [WIDTH-1:0]     w_p;
  logic                 w_beat;
  logic [SUM_W-1:0]     w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [COUNT_W:0]     w_cnt_next;
  logic [COUNT_W-1:0]   w_len_eff;
  logic [COUNT_W:0]     w_len_full;
  logic                 w_done;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_head;

  // Next accumulator/count values and frame-completion detect for the current beat
  always_comb begin
    w_p        = bus.p_in;
    w_beat     = r_vpipe[LATENCY-1];
    w_sum      = SUM_W'(r_acc) + SUM_W'(w_p);
    // The frame length is latched on the first beat, so IDLE looks at the live input
    w_len_eff  = (r_state == S_IDLE) ? bus.frame_len : r_len;
    w_len_full = (w_len_eff == {COUNT_W{1'b0}}) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, w_len_eff};
    if (r_state == S_IDLE) begin
      w_acc_next = ACC_WIDTH'(w_p);
      w_cnt_next = {{COUNT_W{1'b0}}, 1'b1};
    end else begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
      w_cnt_next = {1'b0, r_cnt} + {{COUNT_W{1'b0}}, 1'b1};
    end
`ifdef MULT_ACC_SAT_EN
    if (r_state == S_IDLE) begin
      w_sat_next = 1'b0;
    end else if (r_sat || w_sum[ACC_WIDTH]) begin
      w_acc_next = {ACC_WIDTH{1'b1}};
      w_sat_next = 1'b1;
    end else begin
      w_sat_next = 1'b0;
    end
    w_entry = {w_sat_next, w_len_eff, w_acc_next};
`else
    w_entry = {w_len_eff, w_acc_next};
`endif
    w_done = w_beat && (w_cnt_next == w_len_full);
    w_full = (r_fill == 2'd2);
    w_pop  = (r_fill != 2'd0) && bus.out_ready;
    w_wr   = w_done && (!w_full || w_pop);
    w_head = r_mem[r_rd_ptr];
  end

  // Issue-valid delay line matching the multiplier latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= {LATENCY{1'b0}};
    end else begin
      r_vpipe <= (r_vpipe << 1) | LATENCY'(bus.in_valid);
    end
  end

  // Frame state machine and accumulator; state only moves on a beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= {ACC_WIDTH{1'b0}};
      r_cnt   <= {COUNT_W{1'b0}};
      r_len   <= {COUNT_W{1'b0}};
`ifdef MULT_ACC_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else if (w_beat) begin
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next[COUNT_W-1:0];
      r_len   <= w_len_eff;
      r_state <= w_done ? S_IDLE : S_ACCUM;
`ifdef MULT_ACC_SAT_EN
      r_sat   <= w_sat_next;
`endif
    end
  end

  // Two-entry result FIFO; a push into a full FIFO without a pop is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= {ENTRY_W{1'b0}};
      r_mem[1] <= {ENTRY_W{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_fill   <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + 2'd1;
        2'b01:   r_fill <= r_fill - 2'd1;
        default: r_fill <= r_fill;
      endcase
      if (w_done && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_valid    = (r_fill != 2'd0);
  assign bus.out_sum      = w_head[ACC_WIDTH-1:0];
  assign bus.out_count    = w_head[ACC_WIDTH +: COUNT_W];
  assign bus.overflow_err = r_ovf;
  assign bus.busy         = (r_state == S_ACCUM) || (r_vpipe != {LATENCY{1'b0}});
`ifdef MULT_ACC_SAT_EN
  assign bus.out_sat      = w_head[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_mult_accum_stage.sv
// Randomized bench for mult_accum_stage against a queue-based frame/FIFO model, plus directed literal cases.
module tb_mult_accum_stage;
  localparam int W   = 16;
  localparam int AW  = 16;
  localparam int LAT = 3;
  localparam int CW  = 3;

  typedef struct {
    longint unsigned sum;
    int              cnt;
    bit              sat;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_accum_stage_if #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_W(CW)) ifc ();

  mult_accum_stage #(.WIDTH(W), .ACC_WIDTH(AW), .LATENCY(LAT), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int              checks = 0;
  int              errors = 0;
  bit              chk_en = 1'b0;
  ent_t            m_fifo[$];
  bit              m_ivq[$];
  logic [W-1:0]    pvq[$];
  bit              m_open, m_sat, m_ovf;
  longint unsigned m_sum;
  int              m_cnt, m_len;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_ivq.delete();
    for (int i = 0; i < LAT; i++) m_ivq.push_back(1'b0);
    m_open = 1'b0; m_sat = 1'b0; m_ovf = 1'b0; m_sum = 0; m_cnt = 0; m_len = 0;
  endtask

  // One clock edge of the frame/FIFO rules, using the inputs applied at that edge
  task automatic model_update();
    bit beat, pop, done;
    int lv;
    longint unsigned maxv;
    maxv = (64'd1 << AW) - 64'd1;
    beat = m_ivq.pop_front();
    m_ivq.push_back(ifc.in_valid);
    pop  = (m_fifo.size() != 0) && ifc.out_ready;
    done = 1'b0;
    if (beat) begin
      if (!m_open) begin
        m_sum = ifc.p_in; m_cnt = 1; m_len = ifc.frame_len; m_sat = 1'b0;
      end else begin
        m_sum = m_sum + ifc.p_in;
        m_cnt++;
`ifdef MULT_ACC_SAT_EN
        if (m_sum > maxv) begin m_sum = maxv; m_sat = 1'b1; end
`else
        m_sum = m_sum & maxv;
`endif
      end
      lv     = (m_len == 0) ? (1 << CW) : m_len;
      done   = (m_cnt == lv);
      m_open = !done;
    end
    if (pop) void'(m_fifo.pop_front());
    if (done) begin
      if (m_fifo.size() < 2) m_fifo.push_back('{m_sum, m_len, m_sat});
      else m_ovf = 1'b1;
    end
  endtask

  // p_in carries the value issued LAT steps earlier, like the multiplier would
  task automatic step(input bit iv, input logic [W-1:0] pv);
    ifc.in_valid = iv;
    ifc.p_in     = pvq.pop_front();
    pvq.push_back(pv);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!ifc.out_valid && n < n0 + 40) begin
      step(1'b0, W'($urandom));
      n++;
    end
    chk("wait_out_valid", ifc.out_valid, 1);
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("out_valid", ifc.out_valid, m_fifo.size() != 0);
      chk("overflow_err", ifc.overflow_err, m_ovf);
      chk("busy", ifc.busy, m_open || (m_ivq.sum() with (int'(item)) != 0));
      if (m_fifo.size() != 0) begin
        chk("out_sum", ifc.out_sum, m_fifo[0].sum);
        chk("out_count", ifc.out_count, m_fifo[0].cnt);
`ifdef MULT_ACC_SAT_EN
        chk("out_sat", ifc.out_sat, m_fifo[0].sat);
`endif
      end
    end
  end

  initial begin
    int n;
    ifc.in_valid  = 1'b0;
    ifc.p_in      = '0;
    ifc.frame_len = 3'd1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < LAT; i++) pvq.push_back('0);
    model_clear();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_sum", ifc.out_sum, 0);
    chk("rst_out_count", ifc.out_count, 0);
    chk("rst_overflow", ifc.overflow_err, 0);
    chk("rst_busy", ifc.busy, 0);

    // 4-beat frame: sum 24, visible LAT+4 steps after the first issue
    ifc.frame_len = 3'd4;
    step(1'b1, 16'd3); step(1'b1, 16'd5); step(1'b1, 16'd7); step(1'b1, 16'd9);
    wait_valid(4, n);
    chk("t1_latency", n, LAT + 4);
    chk("t1_sum", ifc.out_sum, 24);
    chk("t1_count", ifc.out_count, 4);
    step(1'b0, 16'd0);
    chk("t1_single", ifc.out_valid, 0);

    // Back-to-back single-beat frames
    ifc.frame_len = 3'd1;
    step(1'b1, 16'd10); step(1'b1, 16'd20); step(1'b1, 16'd30);
    wait_valid(0, n);
    chk("t2_sum0", ifc.out_sum, 10);
    step(1'b0, 16'd0);
    chk("t2_valid1", ifc.out_valid, 1);
    chk("t2_sum1", ifc.out_sum, 20);
    step(1'b0, 16'd0);
    chk("t2_sum2", ifc.out_sum, 30);
    step(1'b0, 16'd0);
    chk("t2_empty", ifc.out_valid, 0);

    // Backpressure: two held, third dropped
    ifc.out_ready = 1'b0;
    step(1'b1, 16'd11); step(1'b1, 16'd22); step(1'b1, 16'd33);
    repeat (4) step(1'b0, 16'd0);
    chk("t3_held_valid", ifc.out_valid, 1);
    chk("t3_held_sum", ifc.out_sum, 11);
    chk("t3_overflow", ifc.overflow_err, 1);
    ifc.out_ready = 1'b1;
    step(1'b0, 16'd0);
    chk("t3_drain_sum", ifc.out_sum, 22);
    step(1'b0, 16'd0);
    chk("t3_drained", ifc.out_valid, 0);
    chk("t3_sticky", ifc.overflow_err, 1);

    // Reset mid-frame discards the partial sum
    do_reset();
    ifc.frame_len = 3'd3;
    step(1'b1, 16'd100); step(1'b1, 16'd200);
    repeat (3) step(1'b0, 16'd0);
    chk("t4_busy", ifc.busy, 1);
    do_reset();
    step(1'b1, 16'd1); step(1'b1, 16'd1); step(1'b1, 16'd1);
    wait_valid(0, n);
    chk("t4_sum", ifc.out_sum, 3);
    chk("t4_overflow", ifc.overflow_err, 0);

    // Accumulator overflow at ACC_WIDTH=16
    ifc.frame_len = 3'd2;
    step(1'b1, 16'hFFFF); step(1'b1, 16'h0002);
    wait_valid(0, n);
`ifdef MULT_ACC_SAT_EN
    chk("t5_sum", ifc.out_sum, 16'hFFFF);
    chk("t5_sat", ifc.out_sat, 1);
`else
    chk("t5_sum", ifc.out_sum, 16'h0001);
`endif
    step(1'b0, 16'd0);

    // frame_len 0 means 2^CW beats
    ifc.frame_len = 3'd0;
    repeat (8) step(1'b1, 16'd1);
    wait_valid(0, n);
    chk("t6_sum", ifc.out_sum, 8);
    chk("t6_count", ifc.out_count, 0);

    // Random traffic, frame_len churn, backpressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) ifc.frame_len = 3'($urandom);
      ifc.out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       step($urandom_range(0, 9) < 7, 16'hFFFF);
        1:       step($urandom_range(0, 9) < 7, W'($urandom_range(0, 15)));
        default: step($urandom_range(0, 9) < 7, W'($urandom));
      endcase
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
